// File: rtl/card_shoe_arbiter.sv
// Shared 5-bit LFSR card shoe arbitrated round-robin between player and dealer.
// One card per grant, automatic reshuffle on exhaustion or on command.
module card_shoe_arbiter #(
    parameter int SHOE_SIZE        = 52,
    parameter int RESHUFFLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] seed,
    input  logic       req_p,
    input  logic       req_d,
    input  logic       shuffle_req,
    output logic       gnt_p,
    output logic       gnt_d,
    output logic [4:0] card,
    output logic       card_valid,
    output logic [5:0] cards_left,
    output logic       shuffling
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SHUFFLE
    } state_t;

    localparam logic [5:0] SHOE_FULL = 6'(SHOE_SIZE);
    localparam logic [3:0] SHUF_LAST = 4'(RESHUFFLE_CYCLES - 1);

    state_t     state_q;
    logic [4:0] lfsr_q;
    logic [4:0] lfsr_d;
    logic [4:0] seed_ld;
    logic [4:0] card_q;
    logic [4:0] card_d;
    logic [5:0] cards_left_q;
    logic [3:0] shuf_cnt_q;
    logic       gnt_p_q;
    logic       gnt_d_q;
    logic       valid_q;
    logic       shuffling_q;
    logic       last_dealer_q;
    logic       pick_p;
    logic       can_issue;

    // A zero seed would lock the LFSR at zero.
    assign seed_ld = (seed == 5'd0) ? 5'd1 : seed;
    assign lfsr_d  = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

    always_comb begin
        card_d = {1'b0, lfsr_q[3:0]} + 5'd1;
        if (card_d > 5'd13) card_d = card_d - 5'd13;
        if (card_d > 5'd10) card_d = 5'd10;
    end

    assign pick_p    = req_p & (~req_d | last_dealer_q);
    assign can_issue = (req_p | req_d) & (cards_left_q != 6'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            lfsr_q        <= seed_ld;
            card_q        <= 5'd0;
            cards_left_q  <= SHOE_FULL;
            shuf_cnt_q    <= 4'd0;
            gnt_p_q       <= 1'b0;
            gnt_d_q       <= 1'b0;
            valid_q       <= 1'b0;
            shuffling_q   <= 1'b0;
            last_dealer_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (shuffle_req) begin
                        state_q     <= S_SHUFFLE;
                        shuffling_q <= 1'b1;
                        shuf_cnt_q  <= 4'd0;
                    end else if (can_issue) begin
                        state_q       <= S_ISSUE;
                        card_q        <= card_d;
                        lfsr_q        <= lfsr_d;
                        cards_left_q  <= cards_left_q - 6'd1;
                        gnt_p_q       <= pick_p;
                        gnt_d_q       <= ~pick_p;
                        valid_q       <= 1'b1;
                        last_dealer_q <= ~pick_p;
                    end
                end
                S_ISSUE: begin
                    gnt_p_q <= 1'b0;
                    gnt_d_q <= 1'b0;
                    valid_q <= 1'b0;
                    if (cards_left_q == 6'd0) begin
                        state_q     <= S_SHUFFLE;
                        shuffling_q <= 1'b1;
                        shuf_cnt_q  <= 4'd0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHUFFLE: begin
                    if (shuf_cnt_q == SHUF_LAST) begin
                        state_q      <= S_IDLE;
                        shuffling_q  <= 1'b0;
                        shuf_cnt_q   <= 4'd0;
                        cards_left_q <= SHOE_FULL;
                        lfsr_q       <= seed_ld;
                    end else begin
                        shuf_cnt_q <= shuf_cnt_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_p      = gnt_p_q;
    assign gnt_d      = gnt_d_q;
    assign card       = card_q;
    assign card_valid = valid_q;
    assign cards_left = cards_left_q;
    assign shuffling  = shuffling_q;

endmodule

// File: tb/tb_card_shoe_arbiter.sv
// Directed bench for card_shoe_arbiter: full shoe instance plus a 3-card shoe.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_card_shoe_arbiter;

    logic       clk = 1'b0;
    logic [4:0] seed;
    logic       rst_a, req_p_a, req_d_a, shuf_a;
    logic       gnt_p_a, gnt_d_a, valid_a, shufing_a;
    logic [4:0] card_a;
    logic [5:0] left_a;
    logic       rst_b, req_p_b, req_d_b, shuf_b;
    logic       gnt_p_b, gnt_d_b, valid_b, shufing_b;
    logic [4:0] card_b;
    logic [5:0] left_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    card_shoe_arbiter #(.SHOE_SIZE(52), .RESHUFFLE_CYCLES(4)) dut_a (
        .clk(clk), .reset(rst_a), .seed(seed),
        .req_p(req_p_a), .req_d(req_d_a), .shuffle_req(shuf_a),
        .gnt_p(gnt_p_a), .gnt_d(gnt_d_a), .card(card_a),
        .card_valid(valid_a), .cards_left(left_a), .shuffling(shufing_a)
    );

    card_shoe_arbiter #(.SHOE_SIZE(3), .RESHUFFLE_CYCLES(4)) dut_b (
        .clk(clk), .reset(rst_b), .seed(seed),
        .req_p(req_p_b), .req_d(req_d_b), .shuffle_req(shuf_b),
        .gnt_p(gnt_p_b), .gnt_d(gnt_d_b), .card(card_b),
        .card_valid(valid_b), .cards_left(left_b), .shuffling(shufing_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a(input logic [4:0] s);
        seed = s; rst_a = 1'b1;
        req_p_a = 1'b0; req_d_a = 1'b0; shuf_a = 1'b0;
        step();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        seed = 5'd1;
        rst_a = 1'b1; req_p_a = 1'b0; req_d_a = 1'b0; shuf_a = 1'b0;
        rst_b = 1'b1; req_p_b = 1'b0; req_d_b = 1'b0; shuf_b = 1'b0;
        #2;
        checks++; if ({gnt_p_a, gnt_d_a, valid_a, shufing_a} !== 4'b0) begin
            errors++; $display("FAIL rst_flags got %b exp 0000", {gnt_p_a, gnt_d_a, valid_a, shufing_a}); end
        checks++; if (card_a !== 5'd0) begin
            errors++; $display("FAIL rst_card got %0d exp 0", card_a); end
        checks++; if (left_a !== 6'd52) begin
            errors++; $display("FAIL rst_left got %0d exp 52", left_a); end
        checks++; if (left_b !== 6'd3) begin
            errors++; $display("FAIL rst_left_b got %0d exp 3", left_b); end
        step();
        rst_a = 1'b0;
    endtask

    task automatic test_sequence();
        logic [4:0] exp_card [5];
        exp_card = '{5'd2, 5'd3, 5'd5, 5'd10, 5'd3};
        req_p_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({gnt_p_a, gnt_d_a, valid_a} !== 3'b101) begin
                errors++; $display("FAIL seq_gnt[%0d] got %b exp 101", i, {gnt_p_a, gnt_d_a, valid_a}); end
            checks++; if (card_a !== exp_card[i]) begin
                errors++; $display("FAIL seq_card[%0d] got %0d exp %0d", i, card_a, exp_card[i]); end
            checks++; if (left_a !== 6'(51 - i)) begin
                errors++; $display("FAIL seq_left[%0d] got %0d exp %0d", i, left_a, 51 - i); end
            if (i == 4) req_p_a = 1'b0;
            step();
            checks++; if ({gnt_p_a, gnt_d_a, valid_a} !== 3'b000) begin
                errors++; $display("FAIL seq_gap[%0d] got %b exp 000", i, {gnt_p_a, gnt_d_a, valid_a}); end
        end
        step();
        checks++; if (left_a !== 6'd47 || valid_a !== 1'b0) begin
            errors++; $display("FAIL seq_end left %0d valid %b exp 47 0", left_a, valid_a); end
    endtask

    task automatic test_seed0();
        reset_a(5'd0);
        req_p_a = 1'b1;
        step();
        req_p_a = 1'b0;
        checks++; if (gnt_p_a !== 1'b1 || card_a !== 5'd2) begin
            errors++; $display("FAIL seed0 gnt %b card %0d exp 1 2", gnt_p_a, card_a); end
        step();
        req_p_a = 1'b1;
        step();
        req_p_a = 1'b0;
        checks++; if (card_a !== 5'd3) begin
            errors++; $display("FAIL seed0_2nd card %0d exp 3", card_a); end
        step();
    endtask

    task automatic test_round_robin();
        reset_a(5'd1);
        req_p_a = 1'b1; req_d_a = 1'b1;
        step();
        checks++; if ({gnt_p_a, gnt_d_a} !== 2'b10 || card_a !== 5'd2) begin
            errors++; $display("FAIL rr_first gnt %b card %0d exp 10 2", {gnt_p_a, gnt_d_a}, card_a); end
        req_p_a = 1'b0;
        step();
        checks++; if ({gnt_p_a, gnt_d_a, valid_a} !== 3'b000) begin
            errors++; $display("FAIL rr_gap got %b exp 000", {gnt_p_a, gnt_d_a, valid_a}); end
        step();
        checks++; if ({gnt_p_a, gnt_d_a} !== 2'b01 || card_a !== 5'd3) begin
            errors++; $display("FAIL rr_second gnt %b card %0d exp 01 3", {gnt_p_a, gnt_d_a}, card_a); end
        req_d_a = 1'b0;
        step();
        req_p_a = 1'b1; req_d_a = 1'b1;
        step();
        checks++; if ({gnt_p_a, gnt_d_a} !== 2'b10 || card_a !== 5'd5) begin
            errors++; $display("FAIL rr_third gnt %b card %0d exp 10 5", {gnt_p_a, gnt_d_a}, card_a); end
        req_p_a = 1'b0;
        step();
        step();
        checks++; if ({gnt_p_a, gnt_d_a} !== 2'b01 || left_a !== 6'd48) begin
            errors++; $display("FAIL rr_fourth gnt %b left %0d exp 01 48", {gnt_p_a, gnt_d_a}, left_a); end
        req_d_a = 1'b0;
        step();
    endtask

    task automatic test_auto_reshuffle();
        logic [4:0] exp_card [3];
        int n;
        logic stray;
        exp_card = '{5'd2, 5'd3, 5'd5};
        seed = 5'd1;
        rst_b = 1'b0;
        req_p_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (gnt_p_b !== 1'b1 || valid_b !== 1'b1 || card_b !== exp_card[i]) begin
                errors++; $display("FAIL ar_card[%0d] gnt %b card %0d exp 1 %0d", i, gnt_p_b, card_b, exp_card[i]); end
            checks++; if (left_b !== 6'(2 - i)) begin
                errors++; $display("FAIL ar_left[%0d] got %0d exp %0d", i, left_b, 2 - i); end
            if (i < 2) step();
        end
        n = 0;
        stray = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!shufing_b) break;
            n++;
            if (gnt_p_b | gnt_d_b | valid_b) stray = 1'b1;
        end
        checks++; if (n !== 4) begin
            errors++; $display("FAIL ar_shuf_len got %0d exp 4", n); end
        checks++; if (stray !== 1'b0 || left_b !== 6'd3 || gnt_p_b !== 1'b0) begin
            errors++; $display("FAIL ar_reload stray %b left %0d gnt %b exp 0 3 0", stray, left_b, gnt_p_b); end
        step();
        req_p_b = 1'b0;
        checks++; if (gnt_p_b !== 1'b1 || card_b !== 5'd2 || left_b !== 6'd2) begin
            errors++; $display("FAIL ar_after gnt %b card %0d left %0d exp 1 2 2", gnt_p_b, card_b, left_b); end
        checks++; if (gnt_d_b !== 1'b0) begin
            errors++; $display("FAIL ar_gnt_d got %b exp 0", gnt_d_b); end
        step();
    endtask

    task automatic test_shuffle_priority();
        int n;
        logic stray;
        reset_a(5'd1);
        shuf_a = 1'b1; req_d_a = 1'b1;
        step();
        shuf_a = 1'b0;
        checks++; if (shufing_a !== 1'b1 || {gnt_p_a, gnt_d_a, valid_a} !== 3'b000) begin
            errors++; $display("FAIL sp_enter shuf %b gnts %b exp 1 000", shufing_a, {gnt_p_a, gnt_d_a, valid_a}); end
        n = 1;
        stray = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (gnt_p_a | gnt_d_a | valid_a) stray = 1'b1;
            if (!shufing_a) break;
            n++;
        end
        checks++; if (n !== 4 || stray !== 1'b0) begin
            errors++; $display("FAIL sp_len got %0d stray %b exp 4 0", n, stray); end
        step();
        req_d_a = 1'b0;
        checks++; if (gnt_d_a !== 1'b1 || card_a !== 5'd2 || left_a !== 6'd51) begin
            errors++; $display("FAIL sp_grant gnt_d %b card %0d left %0d exp 1 2 51", gnt_d_a, card_a, left_a); end
        step();
    endtask

    task automatic test_reset_mid();
        reset_a(5'd1);
        req_p_a = 1'b1;
        step();
        req_p_a = 1'b0;
        step();
        req_p_a = 1'b1;
        step();
        checks++; if (gnt_p_a !== 1'b1 || card_a !== 5'd3) begin
            errors++; $display("FAIL rm_pre gnt %b card %0d exp 1 3", gnt_p_a, card_a); end
        req_p_a = 1'b0;
        #1 rst_a = 1'b1;
        #1;
        checks++; if ({gnt_p_a, gnt_d_a, valid_a, shufing_a} !== 4'b0 || card_a !== 5'd0 || left_a !== 6'd52) begin
            errors++; $display("FAIL rm_issue flags %b card %0d left %0d exp 0000 0 52",
                {gnt_p_a, gnt_d_a, valid_a, shufing_a}, card_a, left_a); end
        step();
        rst_a = 1'b0; req_p_a = 1'b1;
        step();
        req_p_a = 1'b0;
        checks++; if (gnt_p_a !== 1'b1 || card_a !== 5'd2) begin
            errors++; $display("FAIL rm_issue_after gnt %b card %0d exp 1 2", gnt_p_a, card_a); end
        step();
        shuf_a = 1'b1;
        step();
        shuf_a = 1'b0;
        step();
        checks++; if (shufing_a !== 1'b1) begin
            errors++; $display("FAIL rm_in_shuf got %b exp 1", shufing_a); end
        #1 rst_a = 1'b1;
        #1;
        checks++; if (shufing_a !== 1'b0 || left_a !== 6'd52 || card_a !== 5'd0) begin
            errors++; $display("FAIL rm_shuf shuf %b left %0d card %0d exp 0 52 0", shufing_a, left_a, card_a); end
        step();
        rst_a = 1'b0;
        step();
        req_p_a = 1'b1;
        step();
        req_p_a = 1'b0;
        checks++; if (gnt_p_a !== 1'b1 || card_a !== 5'd2 || left_a !== 6'd51) begin
            errors++; $display("FAIL rm_shuf_after gnt %b card %0d left %0d exp 1 2 51", gnt_p_a, card_a, left_a); end
        step();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_seed0();
        test_round_robin();
        test_auto_reshuffle();
        test_shuffle_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/card_shoe_arbiter.md
# card_shoe_arbiter

Arbitrates one shared pseudo-random card source (5-bit LFSR shoe) between two requesters, the player hit path and the dealer draw path, in the blackjack game datapath. Issues one card per grant with a registered grant/valid pulse and tracks the cards remaining in the shoe. Reshuffles automatically when the shoe is exhausted, or on command, and stalls requests while reshuffling.

## Interface
- `SHOE_SIZE`, default 52: cards per shoe before a reshuffle. Legal range 1..63.
- `RESHUFFLE_CYCLES`, default 4: cycles spent in reshuffle. Legal range 1..15.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `seed`  in  5  LFSR seed; loaded on reset and at every reshuffle reload.
- `req_p`  in  1  player card request; a level signal held until `gnt_p`.
- `req_d`  in  1  dealer card request; a level signal held until `gnt_d`.
- `shuffle_req`  in  1  forces a reshuffle; a level signal sampled in IDLE.
- `gnt_p`  out  1  one-cycle grant to the player.
- `gnt_d`  out  1  one-cycle grant to the dealer.
- `card`  out  5  issued card value, 1..10; valid while `card_valid` is high.
- `card_valid`  out  1  high exactly when `gnt_p` or `gnt_d` is high.
- `cards_left`  out  6  cards remaining in the shoe.
- `shuffling`  out  1  high while in the SHUFFLE state.

## Operation
- **LFSR.** 5 bits. Load value is `seed`, or 5'b00001 when `seed` is 0. Feedback is `lfsr[4]^lfsr[2]`. Advance is `lfsr <= {lfsr[3:0], fb}`, and the LFSR advances only on a grant decision.
- **Card mapping.** The mapping is combinational from the current LFSR:
  - t = `lfsr[3:0]` + 1, giving 1..16.
  - If t > 13, then t = t − 13.
  - If t > 10, then t = 10.
- **States.**
  - IDLE:
    - If `shuffle_req` is high, go to SHUFFLE. `shuffle_req` has priority over card requests.
    - Otherwise, if `req_p` or `req_d` is high and `cards_left` > 0, make a grant decision and go to ISSUE.
  - ISSUE (1 cycle):
    - The selected `gnt_*` is high, `card_valid` is high, and `card` holds the value.
    - All requests are ignored in this cycle.
    - Next state is SHUFFLE if `cards_left` == 0, otherwise IDLE.
  - SHUFFLE:
    - `shuffling` is high.
    - A counter runs for `RESHUFFLE_CYCLES` cycles.
    - On the final edge: `cards_left <= SHOE_SIZE`, the LFSR reloads from `seed`, and the state goes to IDLE.
- **Grant decision edge.** On this edge the block:
  - captures the mapped card into the `card` register,
  - advances the LFSR,
  - decrements `cards_left`,
  - sets the `gnt_*` register of the winner.
- **Round-robin arbitration.**
  - A single requester wins outright.
  - When both request, the requester not granted last wins.
  - The `last` flag resets to dealer, so the player wins the first tie.
- **Requests during SHUFFLE** are not dropped. Level requests are served once the block returns to IDLE.
- **Requester rule.** A requester deasserts its request in the cycle after its grant. Because requests are ignored in ISSUE, a request still high during the grant cycle produces no double grant.
- **Reset values.** Reset takes effect immediately, including mid-ISSUE or mid-SHUFFLE:
  - state = IDLE
  - `gnt_p` = `gnt_d` = 0
  - `card` = 0
  - `card_valid` = 0
  - `cards_left` = `SHOE_SIZE`
  - `shuffling` = 0
  - `last` = dealer
  - LFSR = seed-or-1
  - shuffle counter = 0
- **Width.** `cards_left` is 6 bits and never wraps below 0. A grant is impossible when it is 0.

## Timing
- **Latency.** A request sampled high in IDLE at edge N produces grant/valid high during cycle N→N+1.
- **Throughput.** At most one card every 2 cycles.
- **SHUFFLE entry.** SHUFFLE is entered on the edge that ends ISSUE or IDLE. `shuffling` is high for exactly `RESHUFFLE_CYCLES` cycles. The first post-shuffle grant is possible on the edge after `shuffling` falls.
- **Simultaneous events.**
  - `shuffle_req` together with a card request in IDLE: the shuffle wins.
  - `req_p` and `req_d` together: resolved by the round-robin rule.
- **`cards_left` visibility.** `cards_left` updates on the decision edge, so it is already decremented during ISSUE.

## Test plan
- **Sequence check.** Reset with `seed`=1, then issue 5 sequential `req_p`. Required: `card` sequence 2, 3, 5, 10, 3; each `gnt_p` lasts 1 cycle with latency 1; `cards_left` 52→47.
- **Seed 0.** Reset with `seed`=0. Required: identical to seed 1, so the first card is 2.
- **Round-robin.** `req_p` and `req_d` both held from reset, each dropped after its own grant. Required: `gnt_p` (card 2) in the first ISSUE, then `gnt_d` (card 3) two cycles later. No grant is ever issued in back-to-back cycles.
- **Auto-reshuffle.** `SHOE_SIZE`=3, `RESHUFFLE_CYCLES`=4, with `req_p` continuous. Required: cards 2, 3, 5; `cards_left` reaches 0; `shuffling` is high for 4 cycles; `cards_left` returns to 3; the next card is 2.
- **Shuffle priority.** `shuffle_req` and `req_d` asserted together in IDLE. Required: no grant, `shuffling` high for `RESHUFFLE_CYCLES` cycles, then `gnt_d` with card 2 and `cards_left` = `SHOE_SIZE`−1.
- **Reset mid-operation.** Assert `reset` during ISSUE and again mid-SHUFFLE. Required: all outputs immediately return to their reset values, and the first card after release is 2.
